id_ex_stage: RTL

ID/EX pipeline register and operand-forwarding front end for the 64-bit execute stage. It captures decoded control and operands from decode and resolves RAW hazards by forwarding from MEM and WB. It produces SrcAE, SrcBE, ALUControlE, funct3E and BranchE for the ALU, then consumes the ALU's ZeroE to generate the branch/jump redirect.

---
 rtl/core_pkg.sv | 39 +++
 rtl/fwd_mux.sv | 40 ++++
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared execute-stage definitions: ALU op codes, branch conditions,
// forwarding-source select and the registered control bundle.
package core_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_SLT    = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SH1ADD = 4'b1000;
    localparam logic [3:0] ALU_SH2ADD = 4'b1001;
    localparam logic [3:0] ALU_SH3ADD = 4'b1010;
    localparam logic [3:0] ALU_ADDUW  = 4'b1011;

    localparam logic [2:0] BEQ = 3'b000;
    localparam logic [2:0] BNE = 3'b001;
    localparam logic [2:0] BLT = 3'b100;
    localparam logic [2:0] BGE = 3'b101;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic [2:0] funct3;
    } ctrl_e_t;

endpackage

// File: rtl/fwd_mux.sv
// One operand's RAW-hazard forwarding: MEM result beats WB result beats the
// register-file value; x0 is never forwarded.
module fwd_mux
    import core_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic [RA_W-1:0] rd_m_i,
    input  logic            reg_write_m_i,
    input  logic [XLEN-1:0] alu_result_m_i,
    input  logic [RA_W-1:0] rd_w_i,
    input  logic            reg_write_w_i,
    input  logic [XLEN-1:0] result_w_i,
    output logic [XLEN-1:0] data_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            sel = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        data_o = reg_data_i;
        unique case (sel)
            FWD_MEM: data_o = alu_result_m_i;
            FWD_WB:  data_o = result_w_i;
            default: data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, branch target and
// fetch-redirect generation for the 64-bit execute stage.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [RA_W-1:0] Rs1D,
    input  logic [RA_W-1:0] Rs2D,
    input  logic [RA_W-1:0] RdD,
    input  logic [3:0]      ALUControlD,
    input  logic [2:0]      funct3D,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic [RA_W-1:0] RdM,
    input  logic [RA_W-1:0] RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic            ZeroE,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [3:0]      ALUControlE,
    output logic [2:0]      funct3E,
    output logic            BranchE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [RA_W-1:0] RdE,
    output logic [RA_W-1:0] Rs1E,
    output logic [RA_W-1:0] Rs2E,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            ValidE,
    output logic [1:0]      ResultSrcE,
    output logic            PCSrcE
);

    ctrl_e_t         ctrl_q, ctrl_d;
    logic [XLEN-1:0] rd1_q, rd1_d;
    logic [XLEN-1:0] rd2_q, rd2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [RA_W-1:0] rs1_q, rs1_d;
    logic [RA_W-1:0] rs2_q, rs2_d;
    logic [RA_W-1:0] rd_q, rd_d;

    logic [XLEN-1:0] fwd_a, fwd_b;

    // Flush outranks stall; an all-zero register set is a NOP (ADD, no writes).
    always_comb begin
        ctrl_d     = ctrl_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        if (FlushE) begin
            ctrl_d     = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            pc_d       = '0;
            pc_plus4_d = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
        end else if (!StallE) begin
            ctrl_d.valid       = ValidD;
            ctrl_d.reg_write   = RegWriteD;
            ctrl_d.mem_write   = MemWriteD;
            ctrl_d.branch      = BranchD;
            ctrl_d.jump        = JumpD;
            ctrl_d.alu_src     = ALUSrcD;
            ctrl_d.result_src  = ResultSrcD;
            ctrl_d.alu_control = ALUControlD;
            ctrl_d.funct3      = funct3D;
            rd1_d      = RD1D;
            rd2_d      = RD2D;
            imm_d      = ImmExtD;
            pc_d       = PCD;
            pc_plus4_d = PCPlus4D;
            rs1_d      = Rs1D;
            rs2_d      = Rs2D;
            rd_d       = RdD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

    // Forwarding reads live RdM/RdW, so a held instruction still sees new results.
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_a (
        .rs_i           (rs1_q),
        .reg_data_i     (rd1_q),
        .rd_m_i         (RdM),
        .reg_write_m_i  (RegWriteM),
        .alu_result_m_i (ALUResultM),
        .rd_w_i         (RdW),
        .reg_write_w_i  (RegWriteW),
        .result_w_i     (ResultW),
        .data_o         (fwd_a)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_b (
        .rs_i           (rs2_q),
        .reg_data_i     (rd2_q),
        .rd_m_i         (RdM),
        .reg_write_m_i  (RegWriteM),
        .alu_result_m_i (ALUResultM),
        .rd_w_i         (RdW),
        .reg_write_w_i  (RegWriteW),
        .result_w_i     (ResultW),
        .data_o         (fwd_b)
    );

    assign SrcAE       = fwd_a;
    assign SrcBE       = ctrl_q.alu_src ? imm_q : fwd_b;
    assign WriteDataE  = fwd_b;
    assign PCTargetE   = pc_q + imm_q;
    assign PCPlus4E    = pc_plus4_q;
    assign ALUControlE = ctrl_q.alu_control;
    assign funct3E     = ctrl_q.funct3;
    assign BranchE     = ctrl_q.branch;
    assign RdE         = rd_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign JumpE       = ctrl_q.jump;
    assign ValidE      = ctrl_q.valid;
    assign ResultSrcE  = ctrl_q.result_src;
    assign PCSrcE      = ctrl_q.valid & ((ctrl_q.branch & ZeroE) | ctrl_q.jump);

endmodule
